filtro_biquad_cascada: RTL and testbench

Self-sequenced cascade of second-order IIR (biquad, direct form II) sections sharing a single signed multiply-accumulate unit, with an internal FSM generating all register enables and operand selects that the previous filter datapath required from an external controller. Parametrised in word width, fractional bits and number of cascaded sections, with a runtime coefficient bus, start/done handshake, synchronous state clear and saturating arithmetic. It sits between the ADC sample interface and the DAC output stage of the audio filter chain.

---
 rtl/filtro_biquad_cascada.sv | 193 +++++++++++++++++++
 tb/tb_filtro_biquad_cascada.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/filtro_biquad_cascada.sv
// Cascade of direct-form-II biquad sections time-sharing one signed MAC.
// An internal FSM walks F0,F1,Y0,Y1,Y2 per section; five edges per section.
module filtro_biquad_cascada #(
  parameter int unsigned N         = 16,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned SECCIONES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clr,
  input  logic [N-1:0]               uk,
  input  logic [5*N*SECCIONES-1:0]   coef,
  output logic [N-1:0]               yk,
  output logic                       done,
  output logic                       busy
);

  localparam int unsigned ACCW = 2*N + 2;
  localparam int unsigned PW   = 2*N;
  localparam int unsigned CW   = 5*N*SECCIONES;
  localparam int unsigned SW   = (SECCIONES > 1) ? $clog2(SECCIONES) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] F0   = 3'd1;
  localparam logic [2:0] F1   = 3'd2;
  localparam logic [2:0] Y0   = 3'd3;
  localparam logic [2:0] Y1   = 3'd4;
  localparam logic [2:0] Y2   = 3'd5;

  logic [2:0]             state, state_n;
  logic [SW-1:0]          sec;
  logic [CW-1:0]          coef_q;
  logic signed [N-1:0]    x, fk;
  logic signed [N-1:0]    f1 [SECCIONES];
  logic signed [N-1:0]    f2 [SECCIONES];
  logic signed [ACCW-1:0] acc;

  logic signed [N-1:0]    cf [SECCIONES][5];
  logic signed [N-1:0]    f1s_c, f2s_c, ca_c, sb_c, res_c;
  logic signed [PW-1:0]   prod_c;
  logic signed [ACCW-1:0] base_c, prodx_c, acc_n_c;
  logic                   sub_c, last_c;

  // Floor shift by FRAC, then clamp to the N-bit signed range.
  function automatic logic signed [N-1:0] sat(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] sh;
    sh = v >>> FRAC;
    if ((&sh[ACCW-1:N-1]) || !(|sh[ACCW-1:N-1])) return sh[N-1:0];
    return sh[ACCW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction

  // Unpack latched coefficients and pick the current section's delay states.
  always_comb begin
    f1s_c = '0;
    f2s_c = '0;
    for (int s = 0; s < SECCIONES; s++) begin
      for (int i = 0; i < 5; i++) cf[s][i] = coef_q[(5*s+i)*N +: N];
    end
    for (int s = 0; s < SECCIONES; s++) begin
      if (sec == SW'(s)) begin
        f1s_c = f1[s];
        f2s_c = f2[s];
      end
    end
  end

  // Operand select and shared multiply-accumulate.
  always_comb begin
    ca_c   = '0;
    sb_c   = '0;
    base_c = '0;
    sub_c  = 1'b0;
    for (int s = 0; s < SECCIONES; s++) begin
      if (sec == SW'(s)) begin
        case (state)
          F0:      ca_c = cf[s][3];
          F1:      ca_c = cf[s][4];
          Y0:      ca_c = cf[s][0];
          Y1:      ca_c = cf[s][1];
          Y2:      ca_c = cf[s][2];
          default: ca_c = '0;
        endcase
      end
    end
    case (state)
      F0: begin
        sb_c   = f1s_c;
        base_c = {{(ACCW-N){x[N-1]}}, x} <<< FRAC;
        sub_c  = 1'b1;
      end
      F1: begin
        sb_c   = f2s_c;
        base_c = acc;
        sub_c  = 1'b1;
      end
      Y0: sb_c = fk;
      Y1: begin
        sb_c   = f1s_c;
        base_c = acc;
      end
      Y2: begin
        sb_c   = f2s_c;
        base_c = acc;
      end
      default: ;
    endcase
    prod_c  = PW'(ca_c) * PW'(sb_c);
    prodx_c = {{2{prod_c[PW-1]}}, prod_c};
    acc_n_c = sub_c ? (base_c - prodx_c) : (base_c + prodx_c);
    res_c   = sat(acc_n_c);
    last_c  = (sec == SW'(SECCIONES-1));
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = F0;
      F0:      state_n = F1;
      F1:      state_n = Y0;
      Y0:      state_n = Y1;
      Y1:      state_n = Y2;
      Y2:      state_n = last_c ? IDLE : F0;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Datapath registers, delay lines and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec    <= '0;
      coef_q <= '0;
      x      <= '0;
      fk     <= '0;
      acc    <= '0;
      yk     <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      for (int s = 0; s < SECCIONES; s++) begin
        f1[s] <= '0;
        f2[s] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            for (int s = 0; s < SECCIONES; s++) begin
              f1[s] <= '0;
              f2[s] <= '0;
            end
          end
          if (start) begin
            x      <= $signed(uk);
            coef_q <= coef;
            sec    <= '0;
            busy   <= 1'b1;
          end
        end
        F1: begin
          acc <= acc_n_c;
          fk  <= res_c;
        end
        Y2: begin
          acc <= acc_n_c;
          x   <= res_c;
          for (int s = 0; s < SECCIONES; s++) begin
            if (sec == SW'(s)) begin
              f2[s] <= f1[s];
              f1[s] <= fk;
            end
          end
          if (last_c) begin
            yk   <= res_c;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            sec <= sec + SW'(1);
          end
        end
        default: acc <= acc_n_c;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_biquad_cascada.sv
// Directed bench: one-section and two-section instances, Q8.8 coefficients.
module tb_filtro_biquad_cascada;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, clr1, start2, clr2;
  logic [15:0] uk1, uk2;
  logic [79:0] coef1;
  logic [159:0] coef2;
  logic [15:0] yk1, yk2;
  logic        done1, busy1, done2, busy2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  filtro_biquad_cascada #(.N(16), .FRAC(8), .SECCIONES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .clr(clr1), .uk(uk1),
    .coef(coef1), .yk(yk1), .done(done1), .busy(busy1)
  );

  filtro_biquad_cascada #(.N(16), .FRAC(8), .SECCIONES(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .clr(clr2), .uk(uk2),
    .coef(coef2), .yk(yk2), .done(done2), .busy(busy2)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] mk(input int b0, input int b1, input int b2,
                                     input int a1, input int a2);
    return {16'(a2), 16'(a1), 16'(b2), 16'(b1), 16'(b0)};
  endfunction

  // Cycles from the edge after the call until done is seen; -1 on timeout.
  task automatic wait_done(input int which, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (((which == 1) ? done1 : done2) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // One sample: accept, then check latency and output.
  task automatic run(input int which, input int u, input bit c, input int exp,
                     input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    if (which == 1) begin
      uk1 = 16'(u); start1 = 1'b1; clr1 = c;
    end else begin
      uk2 = 16'(u); start2 = 1'b1; clr2 = c;
    end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; clr1 = 1'b0; start2 = 1'b0; clr2 = 1'b0;
    wait_done(which, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check(tag, (which == 1) ? $signed(yk1) : $signed(yk2), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int nd;
    int pulses;
    int d [3];

    reset  = 1'b0;
    start1 = 1'b0; clr1 = 1'b0; uk1 = '0;
    start2 = 1'b0; clr2 = 1'b0; uk2 = '0;
    coef1  = mk(256, 0, 0, 0, 0);
    coef2  = {mk(256, 256, 0, 0, 0), mk(256, 256, 0, 0, 0)};
    repeat (2) @(negedge clk);
    check("rst_yk", $signed(yk1), 0);
    check("rst_done", done1, 0);
    check("rst_busy", busy1, 0);
    check("rst_yk2", $signed(yk2), 0);
    reset = 1'b1;

    // passthrough
    run(1, 1234, 1'b0, 1234, 5, "pass_pos");
    run(1, -77, 1'b0, -77, 5, "pass_neg");

    // single real pole at 0.5
    coef1 = mk(256, 0, 0, -128, 0);
    run(1, 256, 1'b1, 256, 5, "pole0");
    run(1, 0, 1'b0, 128, 5, "pole1");
    run(1, 0, 1'b0, 64, 5, "pole2");
    run(1, 0, 1'b0, 32, 5, "pole3");
    run(1, 0, 1'b0, 16, 5, "pole4");
    run(1, 0, 1'b1, 0, 5, "pole_clr");

    // two-section cascade of (1 + z^-1)
    run(2, 256, 1'b1, 256, 10, "casc0");
    run(2, 0, 1'b0, 512, 10, "casc1");
    run(2, 0, 1'b0, 256, 10, "casc2");
    run(2, 0, 1'b0, 0, 10, "casc3");

    // output saturation with gain 2.0
    coef1 = mk(512, 0, 0, 0, 0);
    run(1, 32767, 1'b1, 32767, 5, "sat_pos");
    run(1, -32768, 1'b0, -32768, 5, "sat_neg");
    // feedback saturation: stored f must clamp to 0x7FFF
    coef1 = mk(512, 0, 0, -512, 0);
    run(1, 16384, 1'b1, 32767, 5, "satf0");
    run(1, 16384, 1'b0, 32767, 5, "satf1");
    coef1 = mk(0, 256, 0, -512, 0);
    run(1, 0, 1'b0, 32767, 5, "sat_state");

    // start and coef changes while busy are ignored
    coef1 = mk(256, 0, 0, 0, 0);
    @(negedge clk);
    uk1 = 16'd100; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    check("hs_busy", busy1, 1);
    @(negedge clk);
    coef1 = mk(512, 0, 0, 0, 0); uk1 = 16'd999; start1 = 1'b1; clr1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; clr1 = 1'b0;
    wait_done(1, lat);
    check("hs_lat", lat, 3);
    check("hs_yk", $signed(yk1), 100);
    @(negedge clk);
    check("hs_idle_busy", busy1, 0);
    check("hs_idle_done", done1, 0);

    // start held high: one acceptance per 6 cycles
    coef1 = mk(256, 0, 0, 0, 0);
    uk1 = 16'd5;
    d = '{-1, -1, -1};
    nd = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int cyc = 1; cyc <= 40 && nd < 3; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1 === 1'b1) begin
        d[nd] = cyc;
        nd++;
      end
    end
    start1 = 1'b0;
    check("held_first", d[0], 6);
    check("held_gap1", d[1] - d[0], 6);
    check("held_gap2", d[2] - d[1], 6);
    check("held_yk", $signed(yk1), 5);
    repeat (8) @(negedge clk);

    // reset in the middle of a computation
    coef1 = mk(256, 0, 0, -128, 0);
    run(1, 256, 1'b1, 256, 5, "rst_pre");
    @(negedge clk);
    uk1 = '0; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_busy", busy1, 0);
    check("mid_yk", $signed(yk1), 0);
    check("mid_done", done1, 0);
    pulses = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done1 === 1'b1) pulses++;
    end
    check("mid_no_done", pulses, 0);
    run(1, 256, 1'b0, 256, 5, "fresh0");
    run(1, 0, 1'b0, 128, 5, "fresh1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
